// File: rtl/gpr_pkg.sv
// Shared defaults and helpers for the pipeline GPR file and its busy scoreboard.
package gpr_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_REG   = 0;

  // Low bit of port k inside a flattened bus of width-w slices.
  function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears (issue wins on the same register),
// registered busy count, and per-port busy lookup with writeback bypass.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_sel,
  input  logic                     iss_vld,
  input  logic [ADDR_W-1:0]        iss_sel,
  input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [ADDR_W:0]  r_cnt;
  logic             w_set;
  logic             w_clr;
  logic             w_inc;
  logic             w_dec;

  assign w_set = iss_vld && (iss_sel != ZERO_SEL);
  assign w_clr = we && (wr_sel != ZERO_SEL) && !(iss_vld && (iss_sel == wr_sel));

  // Count moves only on real 0->1 / 1->0 transitions, so WAW issues and
  // writebacks to idle registers leave it untouched.
  assign w_inc = w_set && !r_busy[iss_sel];
  assign w_dec = w_clr &&  r_busy[wr_sel];

  always_comb begin
    // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
    w_busy_nxt = r_busy;
    if (w_clr) w_busy_nxt[wr_sel]  = 1'b0;
    if (w_set) w_busy_nxt[iss_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    if (!rst_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + (ADDR_W+1)'(1);
        2'b01:   r_cnt <= r_cnt - (ADDR_W+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign busy_cnt = r_cnt;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_busy
    logic [ADDR_W-1:0] w_s;
    assign w_s = rd_sel[slice_lo(k, ADDR_W) +: ADDR_W];
    // A writeback landing this cycle supplies the operand, so it is never busy.
    assign rd_busy[k] = (w_s == ZERO_SEL)           ? 1'b0 :
                        (we && (wr_sel == w_s))     ? 1'b0 :
                        r_busy[w_s];
  end

endmodule

// File: rtl/pipe_gpr_sb.sv
// Pipeline GPR file: NUM_RD combinational read ports with writeback bypass, one write port,
// R0 hardwired to zero, busy scoreboard. Define GPR_TRACE_EN for a simulation write trace.
module pipe_gpr_sb
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_sel,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_vld,
  input  logic [ADDR_W-1:0]        iss_sel,
  input  logic [NUM_RD*ADDR_W-1:0] rd_sel,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(ZERO_REG);

  // Entry 0 has no storage; reads of it are forced to zero below.
  logic [DATA_W-1:0] r_mem [1:DEPTH-1];
  logic              w_wr_en;

  assign w_wr_en = we && (wr_sel != ZERO_SEL);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the array is reset because reset must leave every register reading zero.
    if (!rst_n) begin
      for (int i = 1; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[wr_sel] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
    logic [ADDR_W-1:0] w_s;
    assign w_s = rd_sel[slice_lo(k, ADDR_W) +: ADDR_W];
    assign rd_data[slice_lo(k, DATA_W) +: DATA_W] =
      (w_s == ZERO_SEL)       ? '0      :
      (we && (wr_sel == w_s)) ? wr_data :
      r_mem[w_s];
  end

  gpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wr_sel   (wr_sel),
    .iss_vld  (iss_vld),
    .iss_sel  (iss_sel),
    .rd_sel   (rd_sel),
    .rd_busy  (rd_busy),
    .busy_cnt (busy_cnt)
  );

`ifdef GPR_TRACE_EN
  // $strobe defers printing to the end of the step so busy_cnt shows its post-edge value.
  always @(posedge clk) begin
    if (rst_n && w_wr_en)
      $strobe("R[%02d]=%08X busy_cnt=%0d", wr_sel, wr_data, busy_cnt);
  end
`else
`endif

endmodule

// File: tb/tb_pipe_gpr_sb.sv
// Directed bench for pipe_gpr_sb (64-bit, 64 entries, 4 read ports) with a queued scoreboard.
module tb_pipe_gpr_sb;

  localparam int DW = 64;
  localparam int AW = 6;
  localparam int NR = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               we;
  logic [AW-1:0]      wr_sel;
  logic [DW-1:0]      wr_data;
  logic               iss_vld;
  logic [AW-1:0]      iss_sel;
  logic [NR*AW-1:0]   rd_sel;
  logic [NR*DW-1:0]   rd_data;
  logic [NR-1:0]      rd_busy;
  logic [AW:0]        busy_cnt;

  pipe_gpr_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .NUM_RD (NR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .iss_vld  (iss_vld),
    .iss_sel  (iss_sel),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .busy_cnt (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef enum int {K_DATA, K_BUSY, K_CNT} kind_e;
  typedef struct {
    string         name;
    kind_e         kind;
    int            port;
    logic [DW-1:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs settle after the posedge+1 drive; everything queued for
  // this cycle is compared on the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      case (e.kind)
        K_DATA:  check(e.name, rd_data[e.port*DW +: DW], e.val);
        K_BUSY:  check(e.name, DW'(rd_busy[e.port]), e.val);
        default: check(e.name, DW'(busy_cnt), e.val);
      endcase
    end
  end

  task automatic set_in(input logic w, input int ws, input logic [DW-1:0] wd,
                        input logic iv, input int is);
    we      = w;
    wr_sel  = AW'(ws);
    wr_data = wd;
    iss_vld = iv;
    iss_sel = AW'(is);
  endtask

  task automatic set_rd(input int s0, input int s1, input int s2, input int s3);
    rd_sel = {AW'(s3), AW'(s2), AW'(s1), AW'(s0)};
  endtask

  task automatic exp_data(input string n, input int p, input logic [DW-1:0] v);
    q.push_back('{name: n, kind: K_DATA, port: p, val: v});
  endtask

  task automatic exp_busy(input string n, input int p, input logic b);
    q.push_back('{name: n, kind: K_BUSY, port: p, val: DW'(b)});
  endtask

  task automatic exp_cnt(input string n, input int c);
    q.push_back('{name: n, kind: K_CNT, port: 0, val: DW'(c)});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 0, '0, 1'b0, 0);
    set_rd(1, 2, 3, 63);
    repeat (2) @(posedge clk);
    #1;
    for (int p = 0; p < NR; p++) begin
      exp_data("reset_data", p, '0);
      exp_busy("reset_busy", p, 1'b0);
    end
    exp_cnt("reset_cnt", 0);
    tick;
    rst_n = 1'b1;

    // Write R5, read it through the bypass in the same cycle.
    set_in(1'b1, 5, 64'hDEAD_BEEF, 1'b0, 0);
    set_rd(5, 0, 0, 0);
    exp_data("bypass_r5", 0, 64'hDEAD_BEEF);
    tick;

    // R5 from storage; write to R0 is ignored and R0 reads zero.
    set_in(1'b1, 0, 64'h1234, 1'b0, 0);
    set_rd(5, 0, 0, 0);
    exp_data("read_r5", 0, 64'hDEAD_BEEF);
    exp_busy("read_r5_busy", 0, 1'b0);
    exp_data("r0_during_wr", 1, '0);
    exp_busy("r0_busy", 1, 1'b0);
    tick;

    set_in(1'b0, 0, '0, 1'b0, 0);
    set_rd(0, 5, 0, 0);
    exp_data("r0_after_wr", 0, '0);
    tick;

    // Bypass on port 1.
    set_in(1'b1, 7, 64'hA5A5_A5A5, 1'b0, 0);
    set_rd(5, 7, 0, 0);
    exp_data("bypass_r7", 1, 64'hA5A5_A5A5);
    exp_busy("bypass_r7_busy", 1, 1'b0);
    exp_data("r5_port0", 0, 64'hDEAD_BEEF);
    tick;

    // Issue R3: not visible until the next cycle.
    set_in(1'b0, 0, '0, 1'b1, 3);
    set_rd(3, 7, 0, 0);
    exp_busy("iss_r3_same_cycle", 0, 1'b0);
    exp_cnt("iss_r3_cnt_before", 0);
    exp_data("r7_stored", 1, 64'hA5A5_A5A5);
    tick;

    set_in(1'b0, 0, '0, 1'b0, 0);
    set_rd(3, 0, 0, 0);
    exp_busy("r3_busy", 0, 1'b1);
    exp_cnt("r3_cnt", 1);
    tick;

    // Writeback R3: bypassed data, busy drops combinationally.
    set_in(1'b1, 3, 64'h33, 1'b0, 0);
    set_rd(3, 3, 0, 0);
    exp_data("wb_r3_bypass", 0, 64'h33);
    exp_busy("wb_r3_busy_p0", 0, 1'b0);
    exp_busy("wb_r3_busy_p1", 1, 1'b0);
    exp_cnt("wb_r3_cnt_before", 1);
    tick;

    set_in(1'b0, 0, '0, 1'b0, 0);
    set_rd(3, 0, 0, 0);
    exp_busy("r3_cleared", 0, 1'b0);
    exp_data("r3_stored", 0, 64'h33);
    exp_cnt("r3_cnt_cleared", 0);
    tick;

    // Issue R9, then issue + writeback R9 together.
    set_in(1'b0, 0, '0, 1'b1, 9);
    set_rd(9, 0, 0, 0);
    tick;

    set_in(1'b1, 9, 64'h99, 1'b1, 9);
    set_rd(9, 0, 0, 0);
    exp_cnt("r9_cnt", 1);
    exp_data("r9_coll_bypass", 0, 64'h99);
    exp_busy("r9_coll_busy", 0, 1'b0);
    tick;

    set_in(1'b0, 0, '0, 1'b0, 0);
    set_rd(9, 0, 0, 0);
    exp_busy("r9_still_busy", 0, 1'b1);
    exp_data("r9_coll_data", 0, 64'h99);
    exp_cnt("r9_coll_cnt", 1);
    tick;

    // Issue R4 while writing back busy R9: count unchanged.
    set_in(1'b1, 9, 64'h999, 1'b1, 4);
    set_rd(4, 9, 0, 0);
    exp_busy("r4_iss_same_cycle", 0, 1'b0);
    exp_data("r9_wb_bypass", 1, 64'h999);
    tick;

    // Issue R0: no effect.
    set_in(1'b0, 0, '0, 1'b1, 0);
    set_rd(4, 9, 0, 0);
    exp_busy("r4_busy", 0, 1'b1);
    exp_busy("r9_cleared", 1, 1'b0);
    exp_data("r9_stored", 1, 64'h999);
    exp_cnt("swap_cnt", 1);
    tick;

    // WAW issue to already-busy R4.
    set_in(1'b0, 0, '0, 1'b1, 4);
    set_rd(0, 4, 0, 0);
    exp_data("r0_zero", 0, '0);
    exp_busy("r0_not_busy", 0, 1'b0);
    exp_cnt("iss_r0_cnt", 1);
    tick;

    // Writeback to a non-busy register.
    set_in(1'b1, 10, 64'hAA, 1'b0, 0);
    set_rd(4, 0, 0, 0);
    exp_busy("waw_r4_busy", 0, 1'b1);
    exp_cnt("waw_cnt", 1);
    tick;

    set_in(1'b0, 0, '0, 1'b0, 0);
    set_rd(10, 4, 0, 0);
    exp_data("r10_data", 0, 64'hAA);
    exp_busy("r10_busy", 0, 1'b0);
    exp_cnt("r10_cnt", 1);
    tick;

    // Fill every register R1..R63; R4 is already busy.
    for (int i = 1; i < 64; i++) begin
      set_in(1'b0, 0, '0, 1'b1, i);
      exp_cnt("fill_cnt", 1 + (i - 1) - ((i > 4) ? 1 : 0));
      tick;
    end

    set_in(1'b0, 0, '0, 1'b0, 0);
    set_rd(5, 7, 10, 3);
    exp_data("full_p0", 0, 64'hDEAD_BEEF);
    exp_data("full_p1", 1, 64'hA5A5_A5A5);
    exp_data("full_p2", 2, 64'hAA);
    exp_data("full_p3", 3, 64'h33);
    for (int p = 0; p < NR; p++) exp_busy("full_busy", p, 1'b1);
    exp_cnt("full_cnt", 63);
    tick;

    // Duplicate selects on all ports during a writeback to the top entry.
    set_in(1'b1, 63, 64'h0123_4567_89AB_CDEF, 1'b0, 0);
    set_rd(63, 63, 63, 63);
    for (int p = 0; p < NR; p++) begin
      exp_data("dup_bypass", p, 64'h0123_4567_89AB_CDEF);
      exp_busy("dup_bypass_busy", p, 1'b0);
    end
    exp_cnt("full_cnt_hold", 63);
    tick;

    set_in(1'b0, 0, '0, 1'b0, 0);
    set_rd(63, 63, 63, 63);
    for (int p = 0; p < NR; p++) begin
      exp_data("dup_stored", p, 64'h0123_4567_89AB_CDEF);
      exp_busy("dup_cleared", p, 1'b0);
    end
    exp_cnt("cnt_62", 62);
    tick;

    // Asynchronous reset mid-stream: effect is immediate.
    rst_n = 1'b0;
    set_rd(5, 7, 10, 63);
    for (int p = 0; p < NR; p++) begin
      exp_data("midrst_data", p, '0);
      exp_busy("midrst_busy", p, 1'b0);
    end
    exp_cnt("midrst_cnt", 0);
    tick;
    tick;

    rst_n = 1'b1;
    set_in(1'b0, 0, '0, 1'b1, 2);
    set_rd(2, 5, 0, 0);
    exp_busy("cold_iss_same_cycle", 0, 1'b0);
    exp_cnt("cold_cnt_before", 0);
    tick;

    set_in(1'b0, 0, '0, 1'b0, 0);
    exp_busy("cold_r2_busy", 0, 1'b1);
    exp_data("cold_r5_zero", 1, '0);
    exp_cnt("cold_cnt", 1);
    tick;

    @(negedge clk);
    #1;
    check("queue_drained", DW'(q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
